// File: rtl/ddr3_avl_mem_model.sv
// ddr3_avl_mem_model: cycle-accurate Avalon-MM burst slave standing in for the
// SODIMM DDR3 controller local interface in simulation. Writes go straight into
// a backing store; reads are queued in order and returned after a fixed latency.
// Optional feature: define DDR3_MODEL_BACKPRESSURE_EN to add LFSR-driven
// random de-assertion of avl_ready on top of queue-full backpressure.
module ddr3_avl_mem_model #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned SIZE_W       = 3,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned CMD_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  output logic                                avl_ready,
  input  logic                                avl_burstbegin,
  input  logic [ADDR_W-1:0]                   avl_addr,
  input  logic [SIZE_W-1:0]                   avl_size,
  input  logic                                avl_read_req,
  input  logic                                avl_write_req,
  input  logic [DATA_W-1:0]                   avl_wdata,
  output logic                                avl_rdata_valid,
  output logic [DATA_W-1:0]                   avl_rdata,
  output logic                                err,
  output logic [SIZE_W+$clog2(CMD_DEPTH):0]   rd_outstanding
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = SIZE_W + PTR_W + 1;
  localparam int unsigned MEM_D = 2 ** MEM_AW;
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned REP   = DATA_W / 32;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [SIZE_W-1:0] size;
  } rd_cmd_t;

  typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;

  // Write FSM state and latched burst context
  wr_state_t          wr_state, wr_state_nxt;
  logic [MEM_AW-1:0]  wr_base, wr_base_nxt;
  logic [SIZE_W-1:0]  wr_size, wr_size_nxt;
  logic [SIZE_W-1:0]  wr_cnt, wr_cnt_nxt;

  // Request decode results
  logic               mem_we_c;
  logic [MEM_AW-1:0]  mem_waddr_c;
  logic               push_c;
  logic               err_c;
  logic [SIZE_W-1:0]  req_size_c;

  // Read command queue
  rd_cmd_t            q_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   q_wp, q_rp;
  logic [CNT_W-1:0]   q_cnt, q_cnt_nxt_c;
  logic               full_nxt_c;
  rd_cmd_t            q_head_c;

  // Return engine
  rd_state_t          rd_state, rd_state_nxt;
  logic [MEM_AW-1:0]  rd_addr, rd_addr_nxt;
  logic [SIZE_W-1:0]  rd_left, rd_left_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic               pop_c;
  logic               emit_c;
  logic [DATA_W-1:0]  beat_c;

  // Backing store and per-word written flags
  logic [DATA_W-1:0]  mem [MEM_D];
  logic [MEM_D-1:0]   written;

  logic               ready_nxt_c;
  logic [OUT_W-1:0]   out_nxt_c;

  // Address bits above the backing-store depth are intentionally ignored
  if (ADDR_W > MEM_AW) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^avl_addr[ADDR_W-1:MEM_AW];
  end

  // Write FSM next state plus request classification (accept / error)
  always_comb begin
    wr_state_nxt = wr_state;
    wr_base_nxt  = wr_base;
    wr_size_nxt  = wr_size;
    wr_cnt_nxt   = wr_cnt;
    mem_we_c     = 1'b0;
    mem_waddr_c  = wr_base + MEM_AW'(wr_cnt);
    push_c       = 1'b0;
    err_c        = 1'b0;
    req_size_c   = (avl_size == '0) ? SIZE_W'(1) : avl_size;
    if (avl_ready) begin
      if (avl_write_req) begin
        if (avl_read_req) err_c = 1'b1;
        if (avl_burstbegin) begin
          if (wr_state == WR_BURST) err_c = 1'b1;
          if (avl_size == '0) err_c = 1'b1;
          mem_we_c     = 1'b1;
          mem_waddr_c  = avl_addr[MEM_AW-1:0];
          wr_base_nxt  = avl_addr[MEM_AW-1:0];
          wr_size_nxt  = req_size_c;
          wr_cnt_nxt   = SIZE_W'(1);
          wr_state_nxt = (req_size_c == SIZE_W'(1)) ? WR_IDLE : WR_BURST;
        end else if (wr_state == WR_IDLE) begin
          err_c = 1'b1;
        end else begin
          mem_we_c   = 1'b1;
          wr_cnt_nxt = wr_cnt + SIZE_W'(1);
          if (wr_cnt == wr_size - SIZE_W'(1)) wr_state_nxt = WR_IDLE;
        end
      end else if (avl_read_req) begin
        if (!avl_burstbegin || wr_state == WR_BURST) begin
          err_c = 1'b1;
        end else begin
          push_c = 1'b1;
          if (avl_size == '0) err_c = 1'b1;
        end
      end
    end
  end

  // Write FSM and burst context registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      wr_base  <= '0;
      wr_size  <= '0;
      wr_cnt   <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_base  <= wr_base_nxt;
      wr_size  <= wr_size_nxt;
      wr_cnt   <= wr_cnt_nxt;
    end
  end

  // Backing store: contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= avl_wdata;
  end

  // Written flags select stored data over the address pattern
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) written <= '0;
    else if (mem_we_c) written[mem_waddr_c] <= 1'b1;
  end

  assign q_head_c    = q_mem[q_rp];
  assign q_cnt_nxt_c = q_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
  assign full_nxt_c  = (q_cnt_nxt_c == CNT_W'(CMD_DEPTH));

  // Queue payload storage
  always_ff @(posedge clk) begin
    if (push_c) q_mem[q_wp] <= '{addr: avl_addr[MEM_AW-1:0], size: req_size_c};
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (push_c) q_wp <= q_wp + PTR_W'(1);
      if (pop_c)  q_rp <= q_rp + PTR_W'(1);
      q_cnt <= q_cnt_nxt_c;
    end
  end

  // Return engine: pop when idle, count latency, then stream the burst
  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_left_nxt  = rd_left;
    lat_cnt_nxt  = lat_cnt;
    pop_c        = 1'b0;
    emit_c       = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (q_cnt != '0) begin
          pop_c        = 1'b1;
          rd_addr_nxt  = q_head_c.addr;
          rd_left_nxt  = q_head_c.size;
          lat_cnt_nxt  = LAT_W'(READ_LATENCY - 1);
          rd_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == '0) emit_c = 1'b1;
        else lat_cnt_nxt = lat_cnt - LAT_W'(1);
      end
      RD_BURST: emit_c = 1'b1;
      default:  rd_state_nxt = RD_IDLE;
    endcase
    if (emit_c) begin
      rd_addr_nxt  = rd_addr + MEM_AW'(1);
      rd_left_nxt  = rd_left - SIZE_W'(1);
      rd_state_nxt = (rd_left == SIZE_W'(1)) ? RD_IDLE : RD_BURST;
    end
  end

  // Return engine registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rd_addr  <= '0;
      rd_left  <= '0;
      lat_cnt  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_addr  <= rd_addr_nxt;
      rd_left  <= rd_left_nxt;
      lat_cnt  <= lat_cnt_nxt;
    end
  end

  assign beat_c = written[rd_addr] ? mem[rd_addr] : {REP{32'(rd_addr)}};

  // Read data outputs, sampled from memory at emission time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avl_rdata_valid <= 1'b0;
      avl_rdata       <= '0;
    end else begin
      avl_rdata_valid <= emit_c;
      if (emit_c) avl_rdata <= beat_c;
    end
  end

  assign out_nxt_c = rd_outstanding
                   + (push_c ? OUT_W'(req_size_c) : OUT_W'(0))
                   - OUT_W'(emit_c);

  // Outstanding beat counter and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_outstanding <= '0;
      err            <= 1'b0;
    end else begin
      rd_outstanding <= out_nxt_c;
      err            <= err | err_c;
    end
  end

`ifdef DDR3_MODEL_BACKPRESSURE_EN
  logic [15:0] lfsr, lfsr_nxt_c;

  assign lfsr_nxt_c  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign ready_nxt_c = !full_nxt_c && (lfsr_nxt_c[1:0] != 2'b00);

  // Random backpressure source
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else lfsr <= lfsr_nxt_c;
  end
`else
  assign ready_nxt_c = !full_nxt_c;
`endif

  // Ready reflects post-edge queue occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avl_ready <= 1'b0;
    else avl_ready <= ready_nxt_c;
  end

endmodule
